// File: rtl/cla_4bit_adder.sv
// Registered 4-bit carry-lookahead adder with group propagate/generate for cascading.
// Latency 1 cycle (2 cycles when CLA_INPUT_REG_EN is defined, adding an input stage).
// No backpressure: a new operand pair is accepted every cycle; outputs hold when valid_in=0.
module cla_4bit_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       grp_p,
  output logic       grp_g,
  output logic       valid_out
);

  // Operands as seen by the lookahead logic (ports or input stage).
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_cin;
  logic       op_vld;

`ifdef CLA_INPUT_REG_EN
  logic [3:0] a_in_q, a_in_d;
  logic [3:0] b_in_q, b_in_d;
  logic       cin_in_q, cin_in_d;
  logic       vld_in_q, vld_in_d;

  // Input stage: capture operands only when valid so idle inputs never enter the datapath.
  always_comb begin
    a_in_d   = a_in_q;
    b_in_d   = b_in_q;
    cin_in_d = cin_in_q;
    vld_in_d = valid_in;
    if (valid_in) begin
      a_in_d   = a;
      b_in_d   = b;
      cin_in_d = cin;
    end
  end

  // Input stage registers; reset clears them so an in-flight operation is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_in_q   <= 4'd0;
      b_in_q   <= 4'd0;
      cin_in_q <= 1'b0;
      vld_in_q <= 1'b0;
    end else begin
      a_in_q   <= a_in_d;
      b_in_q   <= b_in_d;
      cin_in_q <= cin_in_d;
      vld_in_q <= vld_in_d;
    end
  end

  assign op_a   = a_in_q;
  assign op_b   = b_in_q;
  assign op_cin = cin_in_q;
  assign op_vld = vld_in_q;
`else
  assign op_a   = a;
  assign op_b   = b;
  assign op_cin = cin;
  assign op_vld = valid_in;
`endif

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;
  logic [3:0] sum_nxt;
  logic       grp_p_nxt;
  logic       grp_g_nxt;

  // Flattened lookahead: every carry is a two-level sum of products, no ripple path.
  always_comb begin
    p    = op_a ^ op_b;
    g    = op_a & op_b;
    c    = '0;
    c[0] = op_cin;
    c[1] = g[0] | (p[0] & op_cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & op_cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & op_cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & op_cin);
    sum_nxt   = p ^ c[3:0];
    grp_p_nxt = &p;
    // Group generate is c4 with the carry-in term removed.
    grp_g_nxt = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

  logic [3:0] sum_q, sum_d;
  logic       cout_q, cout_d;
  logic       grp_p_q, grp_p_d;
  logic       grp_g_q, grp_g_d;
  logic       valid_out_q, valid_out_d;

  // Result next-state: load on a valid operand, otherwise hold the last result.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    grp_p_d     = grp_p_q;
    grp_g_d     = grp_g_q;
    valid_out_d = op_vld;
    if (op_vld) begin
      sum_d   = sum_nxt;
      cout_d  = c[4];
      grp_p_d = grp_p_nxt;
      grp_g_d = grp_g_nxt;
    end
  end

  // Result registers; reset takes priority over a simultaneous valid operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= 4'd0;
      cout_q      <= 1'b0;
      grp_p_q     <= 1'b0;
      grp_g_q     <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      grp_p_q     <= grp_p_d;
      grp_g_q     <= grp_g_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign grp_p     = grp_p_q;
  assign grp_g     = grp_g_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_cla_4bit_adder.sv
// Directed and streamed checks of the registered 4-bit CLA adder.
// Latency under test follows CLA_INPUT_REG_EN (1 or 2 cycles).
// Inputs are driven 1 time unit after each rising edge; outputs sampled there too.
module tb_cla_4bit_adder;

`ifdef CLA_INPUT_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       grp_p;
  logic       grp_g;
  logic       valid_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: result of a+b+cin, delayed by the latency, holding when idle.
  logic       s1_v;
  logic [3:0] s1_a, s1_b;
  logic       s1_c;
  logic [3:0] m_sum;
  logic       m_cout, m_gp, m_gg, m_v;

  cla_4bit_adder dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .grp_p     (grp_p),
    .grp_g     (grp_g),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_load(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
    logic [4:0] full;
    logic [4:0] nocin;
    full   = {1'b0, xa} + {1'b0, xb} + {4'd0, xc};
    nocin  = {1'b0, xa} + {1'b0, xb};
    m_sum  = full[3:0];
    m_cout = full[4];
    m_gp   = ((xa ^ xb) == 4'hF);
    m_gg   = nocin[4];
  endtask

  // One clock: update the reference with the values the DUT samples at this edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      s1_v = 0; s1_a = 0; s1_b = 0; s1_c = 0;
      m_sum = 0; m_cout = 0; m_gp = 0; m_gg = 0; m_v = 0;
    end else if (L == 1) begin
      if (valid_in) model_load(a, b, cin);
      m_v = valid_in;
    end else begin
      if (s1_v) model_load(s1_a, s1_b, s1_c);
      m_v  = s1_v;
      s1_v = valid_in;
      s1_a = a; s1_b = b; s1_c = cin;
    end
    #1;
  endtask

  // Present one operand pair for a single cycle and wait until its result is out.
  task automatic apply(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
    a = xa; b = xb; cin = xc; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    a = 4'hx; b = 4'hx; cin = 1'bx;
    repeat (L - 1) step();
  endtask

  task automatic chk_all(input string tag, input logic [3:0] es, input logic ec,
                         input logic ep, input logic eg, input logic ev);
    chk({tag, ".sum"},   {4'd0, sum},       {4'd0, es});
    chk({tag, ".cout"},  {7'd0, cout},      {7'd0, ec});
    chk({tag, ".grp_p"}, {7'd0, grp_p},     {7'd0, ep});
    chk({tag, ".grp_g"}, {7'd0, grp_g},     {7'd0, eg});
    chk({tag, ".vld"},   {7'd0, valid_out}, {7'd0, ev});
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;
    repeat (3) step();
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_all("idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    apply(4'b0000, 4'b0000, 1'b0);
    chk_all("zero", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

    apply(4'b0101, 4'b0011, 1'b0);
    chk_all("5p3", 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);

    apply(4'b1111, 4'b0001, 1'b0);
    chk_all("15p1", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);

    apply(4'b1010, 4'b0101, 1'b1);
    chk_all("prop_carry", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);

    apply(4'b1111, 4'b1111, 1'b1);
    chk_all("15p15c1", 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);

    apply(4'b1111, 4'b1111, 1'b0);
    chk_all("15p15", 4'b1110, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("hold1", 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0);
    a = 4'b0001; b = 4'b0001; cin = 1'b1;
    step();
    step();
    chk_all("hold2", 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-to-back random stream checked against the reference every cycle.
    for (int i = 0; i < 256 + L; i++) begin
      if (i < 256) begin
        valid_in = 1'b1;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        cin = 1'($urandom_range(0, 1));
      end else begin
        valid_in = 1'b0;
      end
      step();
      if (i >= L - 1)
        chk_all($sformatf("stream%0d", i), m_sum, m_cout, m_gp, m_gg, m_v);
    end

    // Reset while an operation is in flight: no result and no valid pulse afterwards.
    a = 4'b0111; b = 4'b0110; cin = 1'b1; valid_in = 1'b1;
    step();
    a = 4'b1001; b = 4'b0011; cin = 1'b0; valid_in = 1'b1; rst = 1'b1;
    step();
    chk_all("rst_flight", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; valid_in = 1'b0;
    step();
    chk_all("rst_nopulse1", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("rst_nopulse2", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    apply(4'b0110, 4'b0111, 1'b1);
    chk_all("after_rst", 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
